// File: rtl/vga_timing_monitor_if.sv
// Bundle between a VGA timing source and its monitor: sync/video inputs plus monitor results.
interface vga_timing_monitor_if #(
    parameter int CW = 11
);
    logic          hsync;
    logic          vsync;
    logic          display_on;
    logic [5:0]    rgb;
    logic          pix_valid;
    logic [9:0]    pix_x;
    logic [9:0]    pix_y;
    logic [CW-1:0] line_len;
    logic [CW-1:0] frame_lines;
    logic          locked;
    logic          err;
    logic [7:0]    err_count;
    logic [15:0]   frame_crc;

    modport master (
        output hsync, vsync, display_on, rgb,
        input  pix_valid, pix_x, pix_y, line_len, frame_lines, locked, err, err_count, frame_crc
    );

    modport slave (
        input  hsync, vsync, display_on, rgb,
        output pix_valid, pix_x, pix_y, line_len, frame_lines, locked, err, err_count, frame_crc
    );
endinterface

// File: rtl/vga_timing_monitor.sv
// VGA timing monitor: rebuilds coordinates, measures geometry, locks and counts violations; VGA_MON_CRC_EN adds a frame CRC.
// Outputs settle 2 clocks after the input edge that causes them; pure sink, no backpressure.
module vga_timing_monitor #(
    parameter int H_TOTAL     = 800,
    parameter int H_ACTIVE    = 640,
    parameter int V_TOTAL     = 525,
    parameter int V_ACTIVE    = 480,
    parameter bit SYNC_NEG    = 1'b1,
    parameter int LOCK_FRAMES = 2,
    parameter int CW          = 11
) (
    input logic                 clk,
    input logic                 reset,
    vga_timing_monitor_if.slave mon
);
    localparam logic [CW-1:0] CNT_MAX    = '1;
    localparam logic [CW-1:0] H_TOTAL_C  = CW'(H_TOTAL);
    localparam logic [CW-1:0] H_ACTIVE_C = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_TOTAL_C  = CW'(V_TOTAL);
    localparam logic [CW-1:0] V_ACTIVE_C = CW'(V_ACTIVE);
    localparam logic [7:0]    LOCK_C     = 8'(LOCK_FRAMES);

    typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

    logic          hs_r, vs_r, de_r, hs_q, vs_q;
    logic          hs_edge, vs_edge, de_rise, de_fall;
    logic          pix_valid;
    logic [9:0]    pix_x, pix_y;
    logic [CW-1:0] hcnt, acnt, lcnt, vcnt, line_len, frame_lines;
    logic [CW-1:0] hcnt_inc, vcnt_now;
    logic          hcnt_sat, line_bad, frame_bad, mismatch;
    state_t        state;
    logic [7:0]    good;
    logic          m, locked, err;
    logic [7:0]    err_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            hs_r <= 1'b0;
            vs_r <= 1'b0;
            de_r <= 1'b0;
            hs_q <= 1'b0;
            vs_q <= 1'b0;
        end else begin
            hs_r <= mon.hsync ^ SYNC_NEG;
            vs_r <= mon.vsync ^ SYNC_NEG;
            de_r <= mon.display_on;
            hs_q <= hs_r;
            vs_q <= vs_r;
        end
    end

    assign hs_edge  = hs_r & ~hs_q;
    assign vs_edge  = vs_r & ~vs_q;
    assign de_rise  = de_r & ~pix_valid;
    assign de_fall  = ~de_r & pix_valid;
    assign hcnt_sat = (hcnt == CNT_MAX);
    assign hcnt_inc = hcnt_sat ? CNT_MAX : hcnt + CW'(1);
    // The line closing on a coincident hsync edge still belongs to the old frame.
    assign vcnt_now = vcnt + CW'(hs_edge && (acnt != '0) && (vcnt != CNT_MAX));
    assign line_bad  = hs_edge && ((hcnt_inc != H_TOTAL_C) || ((acnt != '0) && (acnt != H_ACTIVE_C)));
    assign frame_bad = vs_edge && ((lcnt != V_TOTAL_C) || (vcnt_now != V_ACTIVE_C));
    assign mismatch  = line_bad | frame_bad;

    always_ff @(posedge clk) begin
        if (reset) begin
            hcnt        <= '0;
            acnt        <= '0;
            lcnt        <= '0;
            vcnt        <= '0;
            line_len    <= '0;
            frame_lines <= '0;
            pix_valid   <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
        end else begin
            pix_valid <= de_r;
            if (hs_edge) begin
                hcnt     <= '0;
                line_len <= hcnt_inc;
                acnt     <= CW'(de_r);
            end else begin
                hcnt <= hcnt_inc;
                if (de_r && (acnt != CNT_MAX)) acnt <= acnt + CW'(1);
            end
            if (vs_edge) begin
                frame_lines <= lcnt;
                lcnt        <= CW'(hs_edge);
                vcnt        <= '0;
            end else begin
                vcnt <= vcnt_now;
                if (hs_edge && (lcnt != CNT_MAX)) lcnt <= lcnt + CW'(1);
            end
            if (de_rise) pix_x <= '0;
            else if (de_r) pix_x <= pix_x + 10'd1;
            if (vs_edge) pix_y <= '0;
            else if (de_fall) pix_y <= pix_y + 10'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= SEARCH;
            good      <= '0;
            m         <= 1'b0;
            locked    <= 1'b0;
            err       <= 1'b0;
            err_count <= '0;
        end else if (hcnt_sat) begin
            if (state == LOCKED) begin
                err <= 1'b1;
                if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            end
            state  <= SEARCH;
            locked <= 1'b0;
            good   <= '0;
            m      <= 1'b0;
        end else begin
            case (state)
                SEARCH: begin
                    if (vs_edge) begin
                        state <= ACQUIRE;
                        good  <= '0;
                        m     <= 1'b0;
                    end
                end
                ACQUIRE: begin
                    if (vs_edge) begin
                        m <= 1'b0;
                        if (m || mismatch) begin
                            good <= '0;
                        end else begin
                            good <= good + 8'd1;
                            if (good + 8'd1 >= LOCK_C) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end
                        end
                    end else if (line_bad) begin
                        m <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (mismatch) begin
                        err    <= 1'b1;
                        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                        locked <= 1'b0;
                        state  <= ACQUIRE;
                        good   <= '0;
                        // A mid-frame fault taints the rest of this frame too.
                        m      <= ~vs_edge;
                    end
                end
                default: state <= SEARCH;
            endcase
        end
    end

`ifdef VGA_MON_CRC_EN
    function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic [5:0] sym);
        logic [15:0] c;
        logic [7:0]  b;
        c = crc;
        b = {2'b00, sym};
        for (int i = 7; i >= 0; i--) begin
            if (c[15] ^ b[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
            else              c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    logic [5:0]  rgb_r;
    logic [15:0] crc_run, frame_crc;

    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_r     <= '0;
            crc_run   <= 16'hFFFF;
            frame_crc <= '0;
        end else begin
            rgb_r <= mon.rgb;
            if (vs_edge) begin
                frame_crc <= crc_run;
                crc_run   <= 16'hFFFF;
            end else if (de_r) begin
                crc_run <= crc_step(crc_run, rgb_r);
            end
        end
    end
    assign mon.frame_crc = frame_crc;
`else
    logic [5:0] unused_rgb;
    assign unused_rgb    = mon.rgb;
    assign mon.frame_crc = '0;
`endif

    assign mon.pix_valid   = pix_valid;
    assign mon.pix_x       = pix_x;
    assign mon.pix_y       = pix_y;
    assign mon.line_len    = line_len;
    assign mon.frame_lines = frame_lines;
    assign mon.locked      = locked;
    assign mon.err         = err;
    assign mon.err_count   = err_count;
endmodule

// File: tb/tb_vga_timing_monitor.sv
// Directed bench for vga_timing_monitor on a scaled-down 40x16 mode; dut0 sees active-low syncs, dut1 active-high.
module tb_vga_timing_monitor;
    localparam int HT = 40, HA = 24, VT = 16, VA = 12, CW = 11;
    localparam int HS_W = 6, DE_START = 10, VS_W = 2, ACT_LINE0 = 3;

    typedef struct {
        int nlines;
        int stretch;
        int chk_pix;
        int chk_lock;
        int exp_ll;
        int exp_fl;
        int exp_lk;
        int exp_er;
        int exp_ec;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       hs_act = 1'b0, vs_act = 1'b0, de = 1'b0;
    logic [5:0] rgb = '0;
    int         n_checks = 0, n_fail = 0;
    int         chk_pix = 0, chk_lock = 0, stretch_at = -1;
    int         mon_en = 0, lock_seen = 0;
    logic [15:0] crc_model = 16'hFFFF, prev_crc = 16'hFFFF;
    vec_t       va[7];
    vec_t       vc[4];

    always #5 clk = ~clk;

    vga_timing_monitor_if #(.CW(CW)) bus0 ();
    vga_timing_monitor_if #(.CW(CW)) bus1 ();

    assign bus0.hsync = ~hs_act;
    assign bus0.vsync = ~vs_act;
    assign bus0.display_on = de;
    assign bus0.rgb = rgb;
    assign bus1.hsync = hs_act;
    assign bus1.vsync = vs_act;
    assign bus1.display_on = de;
    assign bus1.rgb = rgb;

    vga_timing_monitor #(.H_TOTAL(HT), .H_ACTIVE(HA), .V_TOTAL(VT), .V_ACTIVE(VA),
        .SYNC_NEG(1'b1), .LOCK_FRAMES(2), .CW(CW)) dut0 (.clk(clk), .reset(reset), .mon(bus0.slave));
    vga_timing_monitor #(.H_TOTAL(HT), .H_ACTIVE(HA), .V_TOTAL(VT), .V_ACTIVE(VA),
        .SYNC_NEG(1'b0), .LOCK_FRAMES(2), .CW(CW)) dut1 (.clk(clk), .reset(reset), .mon(bus1.slave));

    always @(negedge clk) if (mon_en != 0 && (bus0.locked || bus1.locked)) lock_seen++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic [5:0] sym);
        logic [15:0] c;
        logic [7:0]  b;
        c = crc;
        b = {2'b00, sym};
        for (int i = 7; i >= 0; i--) begin
            if (c[15] ^ b[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
            else              c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, " pix_valid"}, 32'({bus0.pix_valid, bus1.pix_valid}), 0);
        check({tag, " pix_x"}, 32'({bus0.pix_x, bus1.pix_x}), 0);
        check({tag, " pix_y"}, 32'({bus0.pix_y, bus1.pix_y}), 0);
        check({tag, " line_len"}, 32'({bus0.line_len, bus1.line_len}), 0);
        check({tag, " frame_lines"}, 32'({bus0.frame_lines, bus1.frame_lines}), 0);
        check({tag, " locked/err"}, 32'({bus0.locked, bus1.locked, bus0.err, bus1.err}), 0);
        check({tag, " err_count"}, 32'({bus0.err_count, bus1.err_count}), 0);
        check({tag, " frame_crc"}, {bus0.frame_crc, bus1.frame_crc}, 0);
    endtask

    // Mid-line probes; outputs seen at cycle c reflect the input driven at cycle c-2.
    task automatic hooks(input int l, input int c);
        if (chk_pix != 0 && l == ACT_LINE0 + 10) begin
            if (c == DE_START + 1) check("pix blank before row", 32'(bus0.pix_valid), 0);
            if (c == DE_START + 2) check("pix first x", 32'({bus0.pix_valid, bus0.pix_x}), {21'd0, 1'b1, 10'd0});
            if (c == DE_START + 6) check("pix x4", 32'(bus0.pix_x), 4);
            if (c == DE_START + 7) begin
                check("pix_valid row10", 32'({bus0.pix_valid, bus1.pix_valid}), 3);
                check("pix_x col5", 32'(bus0.pix_x), 5);
                check("pix_y row10", 32'(bus0.pix_y), 10);
            end
        end
        if (chk_lock != 0 && l == 0) begin
            if (c == 1) check("lock edge-1", 32'({bus0.locked, bus1.locked}), 0);
            if (c == 2) check("lock edge", 32'({bus0.locked, bus1.locked}), 3);
        end
        if (stretch_at >= 0 && l == stretch_at + 1) begin
            if (c == 1) check("stretch pre locked", 32'(bus0.locked), 1);
            if (c == 2) begin
                check("stretch line_len", 32'(bus0.line_len), HT + 1);
                check("stretch err/locked", 32'({bus0.err, bus0.locked, bus1.err, bus1.locked}), 4'b1010);
                check("stretch err_count", 32'(bus0.err_count), 1);
            end
        end
    endtask

    task automatic drive_line(input int l, input int len);
        for (int c = 0; c < len; c++) begin
            @(negedge clk);
            hooks(l, c);
            hs_act = (c < HS_W);
            vs_act = (l < VS_W);
            de = (l >= ACT_LINE0) && (l < ACT_LINE0 + VA) && (c >= DE_START) && (c < DE_START + HA);
            rgb = 6'((c * 3 + l) % 64);
            if (de) crc_model = crc16_step(crc_model, rgb);
        end
    endtask

    task automatic check_frame(input string tag, input int d, input vec_t v, input logic [15:0] exp_crc);
        logic [CW-1:0] ll, fl;
        logic          lk, er;
        logic [7:0]    ec;
        logic [15:0]   fc;
        if (d == 0) begin
            ll = bus0.line_len; fl = bus0.frame_lines; lk = bus0.locked;
            er = bus0.err; ec = bus0.err_count; fc = bus0.frame_crc;
        end else begin
            ll = bus1.line_len; fl = bus1.frame_lines; lk = bus1.locked;
            er = bus1.err; ec = bus1.err_count; fc = bus1.frame_crc;
        end
        check($sformatf("%s d%0d line_len", tag, d), 32'(ll), v.exp_ll);
        check($sformatf("%s d%0d frame_lines", tag, d), 32'(fl), v.exp_fl);
        check($sformatf("%s d%0d locked/err", tag, d), 32'({lk, er}), 32'(v.exp_lk * 2 + v.exp_er));
        check($sformatf("%s d%0d err_count", tag, d), 32'(ec), v.exp_ec);
        check($sformatf("%s d%0d frame_crc", tag, d), 32'(fc), 32'(exp_crc));
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        logic [15:0] exp_crc;
`ifdef VGA_MON_CRC_EN
        exp_crc = prev_crc;
`else
        exp_crc = 16'h0000;
`endif
        chk_pix = v.chk_pix;
        chk_lock = v.chk_lock;
        stretch_at = v.stretch;
        crc_model = 16'hFFFF;
        for (int l = 0; l < v.nlines; l++) drive_line(l, (l == v.stretch) ? HT + 1 : HT);
        prev_crc = crc_model;
        chk_pix = 0;
        chk_lock = 0;
        stretch_at = -1;
        check_frame(tag, 0, v, exp_crc);
        check_frame(tag, 1, v, exp_crc);
    endtask

    initial begin
        // nlines, stretch, chk_pix, chk_lock, line_len, frame_lines, locked, err, err_count
        va[0] = '{VT, -1, 0, 0, HT, 0,  0, 0, 0};
        va[1] = '{VT, -1, 1, 0, HT, VT, 0, 0, 0};
        va[2] = '{VT, -1, 0, 1, HT, VT, 1, 0, 0};
        va[3] = '{VT,  5, 0, 0, HT, VT, 0, 1, 1};
        va[4] = '{VT, -1, 0, 0, HT, VT, 0, 1, 1};
        va[5] = '{VT, -1, 0, 0, HT, VT, 0, 1, 1};
        va[6] = '{VT, -1, 0, 1, HT, VT, 1, 1, 1};
        vc[0] = '{VT - 1, -1, 0, 0, HT, 0,      0, 0, 0};
        vc[1] = '{VT - 1, -1, 0, 0, HT, VT - 1, 0, 0, 0};
        vc[2] = '{VT - 1, -1, 0, 0, HT, VT - 1, 0, 0, 0};
        vc[3] = '{VT - 1, -1, 0, 0, HT, VT - 1, 0, 0, 0};

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;

        for (int i = 0; i < 7; i++) run_vec($sformatf("ideal/stretch f%0d", i + 1), va[i]);

        // Sync loss while locked: hsync stops, hcnt saturates near idle cycle ~2010.
        for (int k = 0; k < 2200; k++) begin
            @(negedge clk);
            hs_act = 1'b0; vs_act = 1'b0; de = 1'b0;
            if (k == 1900) check("syncloss still locked", 32'({bus0.locked, bus1.locked}), 3);
        end
        check("syncloss locked", 32'({bus0.locked, bus1.locked}), 0);
        check("syncloss err_count", 32'({bus0.err_count, bus1.err_count}), 16'h0202);
        check("syncloss err", 32'({bus0.err, bus1.err}), 3);
        check("syncloss state", 32'({dut0.state, dut1.state}), 0);

        for (int l = 0; l < 6; l++) drive_line(l, HT);
        drive_line(6, 20);
        @(negedge clk);
        check("midframe pix_valid", 32'({bus0.pix_valid, bus1.pix_valid}), 3);
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("midframe reset");
        hs_act = 1'b0; vs_act = 1'b0; de = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        prev_crc = 16'hFFFF;

        mon_en = 1;
        for (int i = 0; i < 4; i++) run_vec($sformatf("short f%0d", i + 1), vc[i]);
        mon_en = 0;
        check("short never locked", 32'(lock_seen), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
